// File: rtl/uart_rx_frontend_if.sv
// Byte hand-off between the UART receive front end and its consumer.
//   rx_data  : received byte holding register
//   rx_valid : rx_data holds an unconsumed byte
//   rx_ready : consumer takes the byte in any cycle where rx_valid && rx_ready
// master = receiver (drives data/valid), slave = consumer (drives ready).
interface uart_rx_frontend_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end with 16x oversampling and a one-byte holding
// register.
//   CLK       : single clock, rising edge
//   reset     : asynchronous, active-high
//   rx        : raw asynchronous line, idle high, LSB first
//   rx_if     : byte hand-off (rx_data / rx_valid out, rx_ready in)
//   frame_err : one-cycle pulse when the stop bit samples low
//   overrun   : sticky, an unconsumed byte was overwritten; clears after accept
//   busy      : receiver is inside a frame (FSM not IDLE)
module uart_rx_frontend #(
  parameter int OVERSAMPLE_DIV = 651
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      rx,
  uart_rx_frontend_if.master        rx_if,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int             DW       = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(OVERSAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, sync_prev;
  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick, shift_en, load, ferr_set, accept;

  // Line synchronizer; sync_prev is one more stage purely for edge detection.
  // All flops reset to the idle-line level so a reset never fakes an edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
  assign accept = rx_if.rx_valid && rx_if.rx_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // START waits 8 ticks (bit midpoint); DATA/STOP then sample every 16 ticks.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:  if (sync_prev && !sync2) state_nxt = START;
      START: if (tick && tick_cnt == 4'd7) state_nxt = sync2 ? IDLE : DATA;
      DATA:  if (tick && tick_cnt == 4'd15) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
             end
      STOP:  if (tick && tick_cnt == 4'd15) begin
               load      = sync2;
               ferr_set  = !sync2;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Divider and tick counters sit at zero in IDLE, so every frame starts its
  // timing from the detected falling edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (state == IDLE)                          tick_cnt <= '0;
      else if (tick && state == START && tick_cnt == 4'd7) tick_cnt <= '0;
      else if (tick)                              tick_cnt <= tick_cnt + 1'b1;

      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shreg <= {sync2, shreg[7:1]};
    end
  end

  // Holding register. A load always wins over an accept; overrun only when
  // the old byte was still pending and not taken in the load cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rx_if.rx_data  <= 8'h00;
      rx_if.rx_valid <= 1'b0;
      overrun        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (load) begin
        rx_if.rx_data  <= shreg;
        rx_if.rx_valid <= 1'b1;
        if (rx_if.rx_valid && !accept) overrun <= 1'b1;
        else if (accept)               overrun <= 1'b0;
      end else if (accept) begin
        rx_if.rx_valid <= 1'b0;
        overrun        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;
  localparam int DIV  = 4;
  localparam int BIT  = 16 * DIV;        // 64 CLK per UART bit
  localparam int LAT  = 3 + 152 * DIV;   // line fall -> load edge: 2 sync + edge + 8+144 ticks

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_frontend_if u_if();

  uart_rx_frontend #(.OVERSAMPLE_DIV(DIV)) dut (
    .CLK(CLK), .reset(reset), .rx(rx), .rx_if(u_if),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // ---------------- behavioural model ----------------
  typedef struct { int c; logic [7:0] b; logic good; } ev_t;
  ev_t evq[$];
  logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  // Frames are scheduled by the sender as "byte b lands at cycle c"; the model
  // applies holding-register rules at that cycle.
  initial forever begin
    logic ld, bad, acc;
    logic [7:0] nb;
    ev_t e;
    @(posedge CLK);
    cyc = cyc + 1;
    if (reset) begin
      m_valid = 0; m_ferr = 0; m_ovr = 0; m_data = 8'h00;
      evq.delete();
    end else begin
      ld = 0; bad = 0; nb = 8'h00;
      while (evq.size() > 0 && evq[0].c <= cyc) begin
        e = evq.pop_front();
        if (e.c == cyc) begin
          if (e.good) begin ld = 1; nb = e.b; end
          else bad = 1;
        end
      end
      acc = m_valid && u_if.rx_ready;
      if (ld && m_valid && !acc) m_ovr = 1;
      else if (acc)              m_ovr = 0;
      if (ld)       begin m_valid = 1; m_data = nb; end
      else if (acc) m_valid = 0;
      m_ferr = bad;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- compare + event monitor ----------------
  int rise_cyc = -1, ferr_cyc = -1, valid_cnt = 0, ferr_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic ovr_seen = 0, pv = 0;

  initial forever begin
    @(negedge CLK);
    if (!reset) begin
      chk("rx_valid", u_if.rx_valid, m_valid);
      chk("rx_data", u_if.rx_data, m_data);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      if (u_if.rx_valid) valid_cnt++;
      if (u_if.rx_valid && !pv && rise_cyc < 0) begin rise_cyc = cyc; rise_data = u_if.rx_data; end
      if (frame_err) begin ferr_cnt++; if (ferr_cyc < 0) ferr_cyc = cyc; end
      if (overrun) ovr_seen = 1;
      pv = u_if.rx_valid;
    end else pv = 0;
  end

  task automatic clr_stats();
    rise_cyc = -1; ferr_cyc = -1; valid_cnt = 0; ferr_cnt = 0; ovr_seen = 0;
  endtask

  // ---------------- stimulus ----------------
  int last_fall = 0;
  int n_sent = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop, input bit hold_low);
    ev_t e;
    @(posedge CLK); #1;
    rx = 1'b0;
    last_fall = cyc;
    n_sent++;
    e.c = cyc + LAT; e.b = b; e.good = stop;
    evq.push_back(e);
    repeat (BIT) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge CLK);
    end
    #1 rx = stop;
    repeat (BIT) @(posedge CLK);
    #1 if (!hold_low) rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.rx_ready = 1'b1;
    repeat (3) @(posedge CLK); #1;
    chk("rst_valid", u_if.rx_valid, 1'b0);
    chk("rst_data", u_if.rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    reset = 1'b0;
    repeat (20) @(posedge CLK);

    // A5 with consumer always ready: one-cycle valid, exact latency
    clr_stats();
    send_byte(8'hA5, 1'b1, 0);
    repeat (10) @(posedge CLK); #1;
    chk("a5_latency", rise_cyc, last_fall + 611);
    chk("a5_data", rise_data, 8'hA5);
    chk("a5_valid_cycles", valid_cnt, 1);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_ovr", ovr_seen, 1'b0);
    chk("model_a5", m_data, 8'hA5);

    // 3C unconsumed, then C3 overwrites -> overrun; accept clears both
    u_if.rx_ready = 1'b0;
    clr_stats();
    send_byte(8'h3C, 1'b1, 0);
    send_byte(8'hC3, 1'b1, 0);
    repeat (5) @(posedge CLK); #1;
    chk("ovr_data", u_if.rx_data, 8'hC3);
    chk("ovr_valid", u_if.rx_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    chk("model_ovr", m_ovr, 1'b1);
    chk("ovr_first", rise_data, 8'h3C);
    u_if.rx_ready = 1'b1;
    @(posedge CLK); #1;
    chk("acc_valid", u_if.rx_valid, 1'b0);
    chk("acc_ovr", overrun, 1'b0);

    // 55 with bad stop bit, line then held low
    clr_stats();
    send_byte(8'h55, 1'b0, 1);
    repeat (500) @(posedge CLK); #1;
    chk("ferr_pulses", ferr_cnt, 1);
    chk("ferr_time", ferr_cyc, last_fall + 611);
    chk("ferr_valid", valid_cnt, 0);
    chk("low_busy", busy, 1'b0);
    rx = 1'b1;
    repeat (100) @(posedge CLK); #1;
    chk("high_busy", busy, 1'b0);
    clr_stats();
    send_byte(8'h96, 1'b1, 0);
    repeat (10) @(posedge CLK); #1;
    chk("recover_data", rise_data, 8'h96);
    chk("recover_valid", valid_cnt, 1);

    // 20-CLK glitch on idle line
    clr_stats();
    @(posedge CLK); #1 rx = 1'b0;
    repeat (10) @(posedge CLK); #1;
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (10) @(posedge CLK); #1 rx = 1'b1;
    repeat (16) @(posedge CLK); #1;
    chk("glitch_busy_lo", busy, 1'b0);
    repeat (700) @(posedge CLK); #1;
    chk("glitch_valid", valid_cnt, 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // reset during bit 4 of FF, then 01
    clr_stats();
    @(posedge CLK); #1 rx = 1'b0;
    repeat (BIT) @(posedge CLK); #1 rx = 1'b1;
    repeat (4 * BIT + BIT / 2) @(posedge CLK); #1;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", u_if.rx_valid, 1'b0);
    chk("midrst_data", u_if.rx_data, 8'h00);
    repeat (5) @(posedge CLK); #1 reset = 1'b0;
    repeat (300) @(posedge CLK); #1;
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_valid", valid_cnt, 0);
    send_byte(8'h01, 1'b1, 0);
    repeat (10) @(posedge CLK); #1;
    chk("rst_next_data", rise_data, 8'h01);
    chk("rst_next_count", valid_cnt, 1);
    chk("rst_next_ferr", ferr_cnt, 0);

    // 00 then FF back-to-back, accept coinciding with the FF load
    u_if.rx_ready = 1'b0;
    clr_stats();
    n_sent = 0;
    fork
      begin
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'hFF, 1'b1, 0);
      end
      begin
        wait (n_sent == 2);
        repeat (LAT - 1) @(posedge CLK);
        #1 u_if.rx_ready = 1'b1;
        @(posedge CLK); #1 u_if.rx_ready = 1'b0;
      end
    join
    repeat (5) @(posedge CLK); #1;
    chk("b2b_first", rise_data, 8'h00);
    chk("b2b_data", u_if.rx_data, 8'hFF);
    chk("b2b_valid", u_if.rx_valid, 1'b1);
    chk("b2b_ovr", ovr_seen, 1'b0);
    chk("model_b2b", m_data, 8'hFF);
    u_if.rx_ready = 1'b1;
    @(posedge CLK); #1;
    chk("b2b_drain", u_if.rx_valid, 1'b0);
    repeat (5) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter OVERSAMPLE_DIV, default 651, the number of CLK cycles per 1/16-bit tick (100 MHz / (9600 x 16)).
REQ-002 SHALL have port CLK  input  1  the single clock for all logic; rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port rx  input  1  raw asynchronous UART line, 8N1, LSB first, idle high.
REQ-005 SHALL have port rx_data  output  8  received byte holding register.
REQ-006 SHALL have port rx_valid  output  1  high while rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the byte in any cycle where rx_valid and rx_ready are both high.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a bad stop bit is detected.
REQ-009 SHALL have port overrun  output  1  sticky flag: an unconsumed byte was overwritten.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use only the synchronized value.
REQ-012 SHALL generate a tick every OVERSAMPLE_DIV cycles from a counter; the counter is held at 0 in IDLE and restarts on start-edge detection.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE -> START: on a synchronized falling edge (previous 1, current 0); a line held low without an edge SHALL NOT start a frame.
REQ-015 START: at tick 8, line 0 -> DATA; line 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample every 16 ticks after the start midpoint, shifting LSB first; after the 8th bit -> STOP.
REQ-017 STOP: sample 16 ticks after bit 7. If the sample is 1, load rx_data and set rx_valid on the next cycle. If the sample is 0, pulse frame_err for 1 cycle and discard the byte. Either way -> IDLE.
REQ-018 rx_valid SHALL fall in the cycle after an accept unless a new byte loads in that same cycle.
REQ-019 A new byte loading with rx_valid=1 and no accept that cycle SHALL overwrite rx_data, keep rx_valid=1, and set overrun.
REQ-020 A load and an accept in the same cycle SHALL leave the new byte valid, with no overrun.
REQ-021 overrun SHALL clear on the cycle after the next accept, or on reset.
REQ-022 rx_data SHALL remain stable while rx_valid=1, except on an overrun load.
REQ-023 Latency: rx_valid rises exactly 1 CLK after the stop-bit sample cycle.

Reset
REQ-024 While reset=1, the block SHALL force: FSM IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1 (idle line).
REQ-025 Reset asserted mid-frame SHALL abort the frame with no partial byte and no flag; after release, the block SHALL wait for a fresh falling edge.

Verification (OVERSAMPLE_DIV=4, so 1 bit = 64 CLK)
REQ-026 Send 8'hA5 with rx_ready=1 -> rx_valid high for 1 cycle, rx_data=8'hA5, frame_err=0, overrun=0.
REQ-027 Send 8'h3C with rx_ready=0, then 8'hC3 -> rx_data=8'hC3, overrun=1; then rx_ready=1 -> rx_valid=0 and overrun=0 on the next cycle.
REQ-028 Send 8'h55 with the stop bit driven 0 -> frame_err single pulse, rx_valid stays 0; line then held low 500 CLK -> no new frame until high then falling.
REQ-029 Apply a 20-CLK low glitch on an idle line -> busy rises then falls by tick 8, no rx_valid, no frame_err.
REQ-030 Assert reset during bit 4 of 8'hFF, release, then send 8'h01 -> only 8'h01 is delivered.
REQ-031 Back-to-back bytes 8'h00 then 8'hFF, with accept coinciding with the second load -> both delivered in order, overrun stays 0.
